// File: rtl/mips_pkg.sv
// Shared MIPS constants: R-type function codes, multiply/divide FSM encoding
// and small helpers used by the decoder, ALU control and mult/div unit.
package mips_pkg;

  localparam int unsigned SIZE      = 32;
  localparam int unsigned FUNC_SIZE = 6;
  localparam int unsigned CNT_W     = 5;

  localparam logic [FUNC_SIZE-1:0] FUNC_MTHI  = 6'b010001;
  localparam logic [FUNC_SIZE-1:0] FUNC_MTLO  = 6'b010011;
  localparam logic [FUNC_SIZE-1:0] FUNC_MULT  = 6'b011000;
  localparam logic [FUNC_SIZE-1:0] FUNC_MULTU = 6'b011001;
  localparam logic [FUNC_SIZE-1:0] FUNC_DIV   = 6'b011010;
  localparam logic [FUNC_SIZE-1:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // True for the four iterative HI/LO producing functions.
  function automatic logic is_muldiv(input logic [FUNC_SIZE-1:0] f);
    return (f == FUNC_MULT) || (f == FUNC_MULTU) ||
           (f == FUNC_DIV)  || (f == FUNC_DIVU);
  endfunction

  function automatic logic [SIZE-1:0] abs_if(input logic [SIZE-1:0] x,
                                             input logic            en);
    return (en && x[SIZE-1]) ? (~x + SIZE'(1)) : x;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers: 32 shift-add or
// restoring shift-subtract steps on magnitudes, then a sign-fix cycle.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [FUNC_SIZE-1:0] i_func,
  input  logic [SIZE-1:0]      i_op_a,
  input  logic [SIZE-1:0]      i_op_b,
  input  logic                 i_flush,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [SIZE-1:0]      o_hi,
  output logic [SIZE-1:0]      o_lo
);

  md_state_e        r_state;
  logic             r_busy;
  logic             r_done;
  logic [SIZE-1:0]  r_hi;
  logic [SIZE-1:0]  r_lo;
  logic [SIZE-1:0]  r_acc;
  logic [SIZE-1:0]  r_q;
  logic [SIZE-1:0]  r_m;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  logic              w_signed;
  logic [SIZE-1:0]   w_abs_a;
  logic [SIZE-1:0]   w_abs_b;
  logic [SIZE:0]     w_add_a;
  logic [SIZE:0]     w_add_b;
  logic [SIZE:0]     w_sum;
  logic              w_ge;
  logic [2*SIZE-1:0] w_prod_neg;
  logic [SIZE-1:0]   w_quot;
  logic [SIZE-1:0]   w_rem;

  // Shared SIZE+1-bit adder: add for multiply, subtract for divide.
  always_comb begin
    w_signed = ~i_func[0];
    w_abs_a  = abs_if(i_op_a, w_signed);
    w_abs_b  = abs_if(i_op_b, w_signed);
    w_add_a  = {1'b0, r_acc};
    w_add_b  = r_q[0] ? {1'b0, r_m} : '0;
    if (r_is_div) begin
      w_add_a = {r_acc, r_q[SIZE-1]};
      w_add_b = {1'b0, r_m};
    end
    w_sum = w_add_a + (r_is_div ? ~w_add_b : w_add_b) + {{SIZE{1'b0}}, r_is_div};
    // Partial remainder with its top bit set always exceeds any divisor.
    w_ge       = r_acc[SIZE-1] | ~w_sum[SIZE];
    w_prod_neg = ~{r_acc, r_q} + {{(2*SIZE-1){1'b0}}, 1'b1};
    w_quot     = r_dz ? '1 : (r_neg_q ? (~r_q + SIZE'(1)) : r_q);
    w_rem      = r_neg_r ? (~r_acc + SIZE'(1)) : r_acc;
  end

  // FSM, datapath iteration and HI/LO update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_flush) begin
            if (i_func == FUNC_MTHI) begin
              r_hi <= i_op_a;
            end else if (i_func == FUNC_MTLO) begin
              r_lo <= i_op_a;
            end else if (is_muldiv(i_func)) begin
              r_state  <= ST_CALC;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_is_div <= i_func[1];
              r_neg_q  <= w_signed & (i_op_a[SIZE-1] ^ i_op_b[SIZE-1]);
              r_neg_r  <= w_signed & i_op_a[SIZE-1];
              r_dz     <= i_func[1] & (i_op_b == '0);
              // Divide keeps the dividend in r_q; multiply keeps the multiplier.
              r_q      <= i_func[1] ? w_abs_a : w_abs_b;
              r_m      <= i_func[1] ? w_abs_b : w_abs_a;
            end
          end
        end
        ST_CALC: begin
          if (i_flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            if (r_is_div) begin
              if (w_ge) begin
                r_acc <= w_sum[SIZE-1:0];
                r_q   <= {r_q[SIZE-2:0], 1'b1};
              end else begin
                r_acc <= {r_acc[SIZE-2:0], r_q[SIZE-1]};
                r_q   <= {r_q[SIZE-2:0], 1'b0};
              end
            end else begin
              r_acc <= w_sum[SIZE:1];
              r_q   <= {w_sum[0], r_q[SIZE-1:1]};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(SIZE - 1)) begin
              r_state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          if (!i_flush) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end else begin
              {r_hi, r_lo} <= r_neg_q ? w_prod_neg : {r_acc, r_q};
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
